// File: rtl/issue_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : issue_sched_if
//  Description : Decode / writeback / branch-resolution bundle for the issue
//                scheduler. The "master" side is the pipeline environment
//                (decode, writeback, branch unit); the "slave" side is the
//                scheduler itself.
//  Signals     : dec_*      decode instruction fields and handshake
//                issue_req_o request pulse toward the issue stage
//                wb_*       register writeback completion
//                branch_done_i / flush_i  branch resolution controls
//                outstanding_o / busy_o / wb_err_o  status
//  Revision    : 1.0  initial release
// ============================================================================
interface issue_sched_if;
  logic       dec_valid_i;
  logic       dec_ready_o;
  logic [4:0] dec_rs1_addr_i;
  logic [4:0] dec_rs2_addr_i;
  logic       dec_rs1_used_i;
  logic       dec_rs2_used_i;
  logic [4:0] dec_rd_addr_i;
  logic       dec_rd_we_i;
  logic       dec_branch_i;
  logic       issue_req_o;
  logic       wb_valid_i;
  logic [4:0] wb_addr_i;
  logic       branch_done_i;
  logic       flush_i;
  logic [3:0] outstanding_o;
  logic       busy_o;
  logic       wb_err_o;

  modport master (
    output dec_valid_i, dec_rs1_addr_i, dec_rs2_addr_i, dec_rs1_used_i,
           dec_rs2_used_i, dec_rd_addr_i, dec_rd_we_i, dec_branch_i,
           wb_valid_i, wb_addr_i, branch_done_i, flush_i,
    input  dec_ready_o, issue_req_o, outstanding_o, busy_o, wb_err_o
  );

  modport slave (
    input  dec_valid_i, dec_rs1_addr_i, dec_rs2_addr_i, dec_rs1_used_i,
           dec_rs2_used_i, dec_rd_addr_i, dec_rd_we_i, dec_branch_i,
           wb_valid_i, wb_addr_i, branch_done_i, flush_i,
    output dec_ready_o, issue_req_o, outstanding_o, busy_o, wb_err_o
  );
endinterface
`default_nettype wire

// File: rtl/issue_sched.sv
`default_nettype none
// ============================================================================
//  Module      : issue_sched
//  Description : Issue scheduler. Tracks pending register writes in a 32-entry
//                scoreboard, stalls decode on RAW/WAW hazards, a full write
//                window or an unresolved branch, and emits exactly one
//                registered req pulse per admitted instruction.
//  Ports       : clk_i  clock, rising edge
//                rst_i  synchronous active-high reset
//                bus    issue_sched_if.slave (decode, writeback, branch, status)
//  Parameters  : MAX_OUTSTANDING  write window size, 1..15
//  Revision    : 1.0  initial release
// ============================================================================
module issue_sched #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  issue_sched_if.slave      bus
);

  localparam logic [3:0] c_MAX_OUT = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PULSE   = 2'd1,
    S_BR_WAIT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pending;
  logic [3:0]  r_count;
  logic        r_br_q;
  logic        r_req;
  logic        r_wb_err;

  logic [31:0] w_clr;
  logic [31:0] w_pend_eff;
  logic [31:0] w_set;
  logic        w_wb_hit;
  logic        w_wb_bad;
  logic [3:0]  w_count_eff;
  logic        w_full;
  logic        w_hazard;
  logic        w_admit;
  logic        w_inc;

  // Writeback side: a same-cycle writeback clears the bit before the hazard
  // check so the dependent instruction is admitted without a bubble.
  always_comb begin
    w_clr      = bus.wb_valid_i ? (32'd1 << bus.wb_addr_i) : 32'd0;
    w_pend_eff = r_pending & ~w_clr;
    w_wb_hit   = bus.wb_valid_i && (bus.wb_addr_i != 5'd0) && r_pending[bus.wb_addr_i];
    w_wb_bad   = bus.wb_valid_i && !w_wb_hit;
    // Window occupancy after this cycle's retirement.
    w_count_eff = r_count - {3'd0, w_wb_hit};
    w_full      = (w_count_eff == c_MAX_OUT);
  end

  always_comb begin
    w_hazard = (bus.dec_rs1_used_i && (bus.dec_rs1_addr_i != 5'd0) && w_pend_eff[bus.dec_rs1_addr_i])
            || (bus.dec_rs2_used_i && (bus.dec_rs2_addr_i != 5'd0) && w_pend_eff[bus.dec_rs2_addr_i])
            || (bus.dec_rd_we_i    && (bus.dec_rd_addr_i  != 5'd0) && w_pend_eff[bus.dec_rd_addr_i]);
    w_admit  = (r_state == S_IDLE) && bus.dec_valid_i && !w_hazard && !w_full && !bus.flush_i;
    w_inc    = w_admit && bus.dec_rd_we_i && (bus.dec_rd_addr_i != 5'd0);
    w_set    = w_inc ? (32'd1 << bus.dec_rd_addr_i) : 32'd0;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (w_admit) w_state_nxt = S_PULSE;
      S_PULSE:   w_state_nxt = r_br_q ? S_BR_WAIT : S_IDLE;
      S_BR_WAIT: if (bus.branch_done_i || bus.flush_i) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_pending <= 32'd0;
      r_count   <= 4'd0;
      r_br_q    <= 1'b0;
      r_req     <= 1'b0;
      r_wb_err  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      // Set is ORed after the clear so a same-register set/clear keeps the bit.
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_count   <= r_count + {3'd0, w_inc} - {3'd0, w_wb_hit};
      r_req     <= w_admit;
      if (w_admit) r_br_q <= bus.dec_branch_i;
      if (w_wb_bad) r_wb_err <= 1'b1;
    end
  end

  // Handshake completes at the end of PULSE so decode fields stay stable
  // across the req rising edge.
  assign bus.dec_ready_o   = (r_state == S_PULSE) && !rst_i;
  assign bus.issue_req_o   = r_req;
  assign bus.outstanding_o = r_count;
  assign bus.busy_o        = (r_state != S_IDLE);
  assign bus.wb_err_o      = r_wb_err;

endmodule
`default_nettype wire

// File: tb/tb_issue_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_issue_sched
//  Description : Directed self-checking bench for issue_sched
//                (MAX_OUTSTANDING = 4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_issue_sched;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  issue_sched_if u_if ();

  issue_sched #(.MAX_OUTSTANDING(4)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling / driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    u_if.dec_valid_i    = 1'b0;
    u_if.dec_rs1_addr_i = 5'd0;
    u_if.dec_rs2_addr_i = 5'd0;
    u_if.dec_rs1_used_i = 1'b0;
    u_if.dec_rs2_used_i = 1'b0;
    u_if.dec_rd_addr_i  = 5'd0;
    u_if.dec_rd_we_i    = 1'b0;
    u_if.dec_branch_i   = 1'b0;
    u_if.wb_valid_i     = 1'b0;
    u_if.wb_addr_i      = 5'd0;
    u_if.branch_done_i  = 1'b0;
    u_if.flush_i        = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    n_total++; if (u_if.dec_ready_o !== 1'b0) $display("FAIL rst_ready_in_reset: got %b want 0", u_if.dec_ready_o); else n_pass++;
    tick();
    n_total++; if (u_if.issue_req_o !== 1'b0) $display("FAIL rst_req: got %b want 0", u_if.issue_req_o); else n_pass++;
    n_total++; if (u_if.busy_o !== 1'b0) $display("FAIL rst_busy: got %b want 0", u_if.busy_o); else n_pass++;
    n_total++; if (u_if.outstanding_o !== 4'd0) $display("FAIL rst_outstanding: got %0d want 0", u_if.outstanding_o); else n_pass++;
    n_total++; if (u_if.wb_err_o !== 1'b0) $display("FAIL rst_wb_err: got %b want 0", u_if.wb_err_o); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  // Four independent writes x1..x4: req on cycles 1,3,5,7.
  task automatic test_independent();
    for (int i = 1; i <= 4; i++) begin
      u_if.dec_valid_i   = 1'b1;
      u_if.dec_rd_addr_i = 5'(i);
      u_if.dec_rd_we_i   = 1'b1;
      tick();
      n_total++; if (u_if.issue_req_o !== 1'b1) $display("FAIL ind_req_hi%0d: got %b want 1", i, u_if.issue_req_o); else n_pass++;
      n_total++; if (u_if.dec_ready_o !== 1'b1) $display("FAIL ind_ready%0d: got %b want 1", i, u_if.dec_ready_o); else n_pass++;
      n_total++; if (u_if.outstanding_o !== 4'(i)) $display("FAIL ind_outstanding%0d: got %0d want %0d", i, u_if.outstanding_o, i); else n_pass++;
      tick();
      n_total++; if (u_if.issue_req_o !== 1'b0) $display("FAIL ind_req_lo%0d: got %b want 0", i, u_if.issue_req_o); else n_pass++;
    end
    u_if.dec_valid_i = 1'b0;
  endtask

  // Pending {1,2,3,4}, count 4: fifth write stalls until a same-cycle wb.
  task automatic test_full();
    u_if.dec_valid_i   = 1'b1;
    u_if.dec_rd_addr_i = 5'd5;
    u_if.dec_rd_we_i   = 1'b1;
    tick();
    n_total++; if (u_if.issue_req_o !== 1'b0) $display("FAIL full_stall_req: got %b want 0", u_if.issue_req_o); else n_pass++;
    n_total++; if (u_if.busy_o !== 1'b0) $display("FAIL full_stall_busy: got %b want 0", u_if.busy_o); else n_pass++;
    n_total++; if (u_if.outstanding_o !== 4'd4) $display("FAIL full_stall_outstanding: got %0d want 4", u_if.outstanding_o); else n_pass++;
    u_if.wb_valid_i = 1'b1;
    u_if.wb_addr_i  = 5'd2;
    tick();
    n_total++; if (u_if.issue_req_o !== 1'b1) $display("FAIL full_bypass_req: got %b want 1", u_if.issue_req_o); else n_pass++;
    n_total++; if (u_if.outstanding_o !== 4'd4) $display("FAIL full_bypass_outstanding: got %0d want 4", u_if.outstanding_o); else n_pass++;
    u_if.wb_valid_i = 1'b0;
    tick();
    u_if.dec_valid_i = 1'b0;
    u_if.dec_rd_we_i = 1'b0;
  endtask

  // Pending {1,3,4,5}.
  task automatic test_raw();
    u_if.wb_valid_i = 1'b1;
    u_if.wb_addr_i  = 5'd4;
    tick();
    u_if.wb_valid_i = 1'b0;
    n_total++; if (u_if.outstanding_o !== 4'd3) $display("FAIL raw_wb4_outstanding: got %0d want 3", u_if.outstanding_o); else n_pass++;
    // rs1=5 pending -> stall
    u_if.dec_valid_i    = 1'b1;
    u_if.dec_rs1_addr_i = 5'd5;
    u_if.dec_rs1_used_i = 1'b1;
    tick();
    n_total++; if (u_if.issue_req_o !== 1'b0) $display("FAIL raw_stall_req: got %b want 0", u_if.issue_req_o); else n_pass++;
    u_if.wb_valid_i = 1'b1;
    u_if.wb_addr_i  = 5'd5;
    tick();
    u_if.wb_valid_i = 1'b0;
    n_total++; if (u_if.issue_req_o !== 1'b1) $display("FAIL raw_bypass_req: got %b want 1", u_if.issue_req_o); else n_pass++;
    n_total++; if (u_if.outstanding_o !== 4'd2) $display("FAIL raw_bypass_outstanding: got %0d want 2", u_if.outstanding_o); else n_pass++;
    tick();
    // rs1=x0 never stalls
    u_if.dec_rs1_addr_i = 5'd0;
    tick();
    n_total++; if (u_if.issue_req_o !== 1'b1) $display("FAIL raw_x0_req: got %b want 1", u_if.issue_req_o); else n_pass++;
    tick();
    // rs1=3 pending but unused -> no stall
    u_if.dec_rs1_addr_i = 5'd3;
    u_if.dec_rs1_used_i = 1'b0;
    tick();
    n_total++; if (u_if.issue_req_o !== 1'b1) $display("FAIL raw_unused_req: got %b want 1", u_if.issue_req_o); else n_pass++;
    tick();
    // rs2=3 pending -> stall
    u_if.dec_rs2_addr_i = 5'd3;
    u_if.dec_rs2_used_i = 1'b1;
    tick();
    n_total++; if (u_if.issue_req_o !== 1'b0) $display("FAIL raw_rs2_stall: got %b want 0", u_if.issue_req_o); else n_pass++;
    // WAW on x1 -> stall
    u_if.dec_rs2_used_i = 1'b0;
    u_if.dec_rd_addr_i  = 5'd1;
    u_if.dec_rd_we_i    = 1'b1;
    tick();
    n_total++; if (u_if.issue_req_o !== 1'b0) $display("FAIL waw_stall: got %b want 0", u_if.issue_req_o); else n_pass++;
    clear_inputs();
  endtask

  // Pending {1,3}: admit rd=3 while x3 writes back; bit must stay set.
  task automatic test_set_wins();
    u_if.dec_valid_i   = 1'b1;
    u_if.dec_rd_addr_i = 5'd3;
    u_if.dec_rd_we_i   = 1'b1;
    u_if.wb_valid_i    = 1'b1;
    u_if.wb_addr_i     = 5'd3;
    tick();
    u_if.wb_valid_i = 1'b0;
    n_total++; if (u_if.issue_req_o !== 1'b1) $display("FAIL setwin_req: got %b want 1", u_if.issue_req_o); else n_pass++;
    n_total++; if (u_if.outstanding_o !== 4'd2) $display("FAIL setwin_outstanding: got %0d want 2", u_if.outstanding_o); else n_pass++;
    n_total++; if (u_if.wb_err_o !== 1'b0) $display("FAIL setwin_err: got %b want 0", u_if.wb_err_o); else n_pass++;
    tick();
    u_if.dec_rd_we_i    = 1'b0;
    u_if.dec_rs1_addr_i = 5'd3;
    u_if.dec_rs1_used_i = 1'b1;
    tick();
    n_total++; if (u_if.issue_req_o !== 1'b0) $display("FAIL setwin_still_pending: got %b want 0", u_if.issue_req_o); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_branch();
    u_if.dec_valid_i  = 1'b1;
    u_if.dec_branch_i = 1'b1;
    tick();
    n_total++; if (u_if.issue_req_o !== 1'b1) $display("FAIL br_req: got %b want 1", u_if.issue_req_o); else n_pass++;
    tick();
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      n_total++; if (u_if.busy_o !== 1'b1) $display("FAIL br_wait_busy%0d: got %b want 1", k, u_if.busy_o); else n_pass++;
      n_total++; if (u_if.dec_ready_o !== 1'b0) $display("FAIL br_wait_ready%0d: got %b want 0", k, u_if.dec_ready_o); else n_pass++;
      n_total++; if (u_if.issue_req_o !== 1'b0) $display("FAIL br_wait_req%0d: got %b want 0", k, u_if.issue_req_o); else n_pass++;
      if (k < 2) tick();
    end
    u_if.branch_done_i = 1'b1;
    tick();
    u_if.branch_done_i = 1'b0;
    n_total++; if (u_if.busy_o !== 1'b0) $display("FAIL br_done_busy: got %b want 0", u_if.busy_o); else n_pass++;
    u_if.dec_valid_i = 1'b1;
    tick();
    n_total++; if (u_if.issue_req_o !== 1'b1) $display("FAIL br_next_req: got %b want 1", u_if.issue_req_o); else n_pass++;
    tick();
    // Flush exit
    u_if.dec_branch_i = 1'b1;
    tick();
    tick();
    clear_inputs();
    tick();
    tick();
    n_total++; if (u_if.busy_o !== 1'b1) $display("FAIL brf_wait_busy: got %b want 1", u_if.busy_o); else n_pass++;
    u_if.flush_i = 1'b1;
    tick();
    n_total++; if (u_if.busy_o !== 1'b0) $display("FAIL brf_exit_busy: got %b want 0", u_if.busy_o); else n_pass++;
    n_total++; if (u_if.outstanding_o !== 4'd2) $display("FAIL brf_outstanding: got %0d want 2", u_if.outstanding_o); else n_pass++;
    // Flush in IDLE blocks admission
    u_if.dec_valid_i = 1'b1;
    tick();
    n_total++; if (u_if.issue_req_o !== 1'b0) $display("FAIL flush_idle_block: got %b want 0", u_if.issue_req_o); else n_pass++;
    u_if.flush_i        = 1'b0;
    u_if.dec_rs1_addr_i = 5'd1;
    u_if.dec_rs1_used_i = 1'b1;
    tick();
    n_total++; if (u_if.issue_req_o !== 1'b0) $display("FAIL brf_pending_kept: got %b want 0", u_if.issue_req_o); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_error();
    u_if.wb_valid_i = 1'b1;
    u_if.wb_addr_i  = 5'd7;
    tick();
    u_if.wb_valid_i = 1'b0;
    n_total++; if (u_if.wb_err_o !== 1'b1) $display("FAIL err_set: got %b want 1", u_if.wb_err_o); else n_pass++;
    n_total++; if (u_if.outstanding_o !== 4'd2) $display("FAIL err_outstanding: got %0d want 2", u_if.outstanding_o); else n_pass++;
    tick();
    n_total++; if (u_if.wb_err_o !== 1'b1) $display("FAIL err_sticky: got %b want 1", u_if.wb_err_o); else n_pass++;
  endtask

  task automatic test_reset_mid();
    u_if.dec_valid_i   = 1'b1;
    u_if.dec_rd_addr_i = 5'd9;
    u_if.dec_rd_we_i   = 1'b1;
    tick();
    n_total++; if (u_if.issue_req_o !== 1'b1) $display("FAIL rmid_pulse: got %b want 1", u_if.issue_req_o); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if (u_if.dec_ready_o !== 1'b0) $display("FAIL rmid_ready_gated: got %b want 0", u_if.dec_ready_o); else n_pass++;
    tick();
    n_total++; if (u_if.issue_req_o !== 1'b0) $display("FAIL rmid_req: got %b want 0", u_if.issue_req_o); else n_pass++;
    n_total++; if (u_if.busy_o !== 1'b0) $display("FAIL rmid_busy: got %b want 0", u_if.busy_o); else n_pass++;
    n_total++; if (u_if.outstanding_o !== 4'd0) $display("FAIL rmid_outstanding: got %0d want 0", u_if.outstanding_o); else n_pass++;
    n_total++; if (u_if.wb_err_o !== 1'b0) $display("FAIL rmid_err: got %b want 0", u_if.wb_err_o); else n_pass++;
    rst = 1'b0;
    // x1 was pending before reset; scoreboard cleared so no stall now.
    u_if.dec_rd_we_i    = 1'b0;
    u_if.dec_rs1_addr_i = 5'd1;
    u_if.dec_rs1_used_i = 1'b1;
    tick();
    n_total++; if (u_if.issue_req_o !== 1'b1) $display("FAIL rmid_pending_cleared: got %b want 1", u_if.issue_req_o); else n_pass++;
    tick();
    clear_inputs();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    clear_inputs();
    test_reset();
    test_independent();
    test_full();
    test_raw();
    test_set_wins();
    test_branch();
    test_error();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/issue_sched.md
# issue_sched

Issue scheduler that sequences the edge-triggered issue stage. It holds a 32-entry register scoreboard and counts outstanding register writes. It stalls decode on RAW/WAW hazards, a full write window, or an unresolved branch. For each admitted instruction it produces one clean `req` pulse, so the issue stage sees exactly one rising edge per instruction.

## Interface
- `MAX_OUTSTANDING`, default 4: maximum issued-but-not-written-back register writes; legal range 1..15.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous reset, active-high.
- `dec_valid_i`  in  1  decode presents an instruction; fields are held stable until accepted.
- `dec_ready_o`  out  1  acceptance; decode advances on `dec_valid_i & dec_ready_o`.
- `dec_rs1_addr_i`, `dec_rs2_addr_i`  in  5 each  source registers.
- `dec_rs1_used_i`, `dec_rs2_used_i`  in  1 each  source actually read.
- `dec_rd_addr_i`  in  5  destination register.
- `dec_rd_we_i`  in  1  instruction writes the register file.
- `dec_branch_i`  in  1  instruction uses PC_ALU as a branch/jump.
- `issue_req_o`  out  1  request pulse to the issue stage `req_i`.
- `wb_valid_i`  in  1  a register write completes this cycle.
- `wb_addr_i`  in  5  register written.
- `branch_done_i`  in  1  outstanding branch resolved.
- `flush_i`  in  1  abandon branch wait and return to IDLE.
- `outstanding_o`  out  4  current outstanding write count.
- `busy_o`  out  1  state != IDLE.
- `wb_err_o`  out  1  sticky: writeback hit a non-pending register or x0.

## Operation
- State machine: IDLE, PULSE, BR_WAIT.
- Hazard check in IDLE is the OR of:
  - `rs1_used & rs1!=0 & pend_eff[rs1]`
  - `rs2_used & rs2!=0 & pend_eff[rs2]`
  - WAW: `rd_we & rd!=0 & pend_eff[rd]`
- `pend_eff = pending & ~clr`, where `clr` is the one-hot of `wb_addr_i` when `wb_valid_i` is high. A same-cycle writeback therefore bypasses the stall.
- `full = (outstanding == MAX_OUTSTANDING)`. Full is evaluated after the same-cycle writeback decrement.
- IDLE → PULSE when `dec_valid_i & ~hazard & ~full & ~flush_i`. On that edge:
  - set `pending[rd]` if `rd_we & rd!=0`, and increment the count;
  - latch `dec_branch_i` into `br_q`.
- PULSE:
  - `issue_req_o` = 1 and `dec_ready_o` = 1 (combinational, state==PULSE).
  - Next state is BR_WAIT if `br_q`, else IDLE.
- BR_WAIT:
  - Hold until `branch_done_i | flush_i`, then go to IDLE.
  - `dec_ready_o` = 0.
- `flush_i` in IDLE blocks admission for that cycle. In PULSE it has no effect: the pulse completes and the instruction is not recalled.
- The scoreboard is never modified by `flush_i`. Issued writes always complete.
- Writeback:
  - `wb_valid_i` with a pending register and addr != 0 clears the bit and decrements the count.
  - Otherwise it is ignored and sets `wb_err_o`.
- Set and clear of the same register in the same cycle: the set wins and the count is unchanged (+1 −1).
- Count arithmetic: 4-bit unsigned. Increment is impossible when full; decrement is impossible at 0 (the error path above applies instead).

## Timing
- Reset values:
  - state IDLE, `pending` = 0, count 0, `br_q` 0;
  - `issue_req_o` 0, `dec_ready_o` 0, `busy_o` 0, `outstanding_o` 0, `wb_err_o` 0.
- `issue_req_o` is registered. It rises on the edge that leaves IDLE and falls one cycle later.
- Decode fields stay stable across the `req` rising edge, because the handshake completes at the end of PULSE.
- Minimum issue spacing is 2 cycles, so `req` has a guaranteed low phase between instructions. Peak throughput is 1 instruction per 2 cycles.
- Branch penalty: at least 1 cycle in BR_WAIT. `branch_done_i` in the first BR_WAIT cycle returns to IDLE on the next edge.
- `outstanding_o` and `pending` update on the same edge as admission or writeback.
- Reset mid-operation: all state returns to the reset values on the next edge. No pulse is emitted in the reset cycle.
- `dec_ready_o` is 0 whenever `rst_i` is high.

## Test plan
- Independent stream: 4 ALU ops with rd=1..4 and no sources → `issue_req_o` high on cycles 1,3,5,7; `outstanding_o` reaches 4.
- Full window: with MAX_OUTSTANDING=4 and 4 pending, a 5th instruction stalls in IDLE. `wb_valid_i` with `wb_addr_i`=2 admits it in that same cycle; `outstanding_o` stays 4.
- RAW/bypass: x5 pending, next instruction reads rs1=5 → stall. `wb_valid_i`/`wb_addr_i`=5 → admitted that cycle, pulse on the next. Reading rs1=0 with any pending state → no stall.
- Branch: `dec_branch_i`=1 → PULSE then BR_WAIT with `busy_o`=1 and `dec_ready_o`=0 for 3 cycles. `branch_done_i` → IDLE; the next instruction pulses 2 cycles later. Repeating with `flush_i` instead of `branch_done_i` gives the same exit and an unchanged `pending`.
- Error/reset: `wb_valid_i` with `wb_addr_i`=7 when x7 is not pending → `wb_err_o`=1 and the count is unchanged. Asserting `rst_i` while in PULSE → next cycle all outputs are 0 and `pending` is 0.
